axi_lite_arbiter: RTL and testbench



---
 rtl/axi_lite_pkg.sv | 17 +
 rtl/axi_lite_if.sv | 35 +++
 rtl/rr_arb2.sv | 24 ++
 rtl/axi_lite_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared types and constants for the AXI4-Lite arbiter
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } arb_state_t;

  typedef logic master_id_t;

endpackage

// File: rtl/axi_lite_if.sv
// rtl/axi_lite_if.sv - AXI4-Lite bundle with master and slave views
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wmask;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way winner pick, round-robin or fixed priority to m1
module rr_arb2
  import axi_lite_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic [1:0] req,
  input  master_id_t last,
  output master_id_t winner,
  output logic       any
);

  // Lone requester wins; on a tie either the master not served last or m1 wins
  always_comb begin
    any    = |req;
    winner = 1'b0;
    if (req == 2'b10) begin
      winner = 1'b1;
    end else if (req == 2'b11) begin
      winner = RR_EN ? ~last : 1'b1;
    end
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// rtl/axi_lite_arbiter.sv - 2-to-1 AXI4-Lite arbiter, one transaction in flight
module axi_lite_arbiter
  import axi_lite_pkg::*;
#(
  parameter bit RR_EN  = 1'b1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  axi_lite_if.slave  m0,
  axi_lite_if.slave  m1,
  axi_lite_if.master s,
  output logic [1:0] grant
);

  arb_state_t          state, state_n;
  master_id_t          owner, owner_n;
  master_id_t          last, last_n;
  master_id_t          win_id;
  logic                win_any;
  logic                win_ar;
  logic                aw_done, aw_done_n;
  logic                w_done, w_done_n;
  logic [1:0]          req;

  logic                own_arvalid, own_awvalid, own_wvalid, own_rready, own_bready;
  logic [ADDR_W-1:0]   own_araddr, own_awaddr;
  logic [DATA_W-1:0]   own_wdata;
  logic [DATA_W/8-1:0] own_wmask;
  logic [DATA_W-1:0]   rdata_bc;

  logic                aw_hs, w_hs, aw_fin, w_fin;
  logic                o_arready, o_rvalid, o_awready, o_wready, o_bvalid;

  assign req = {m1.arvalid | m1.awvalid, m0.arvalid | m0.awvalid};

  rr_arb2 #(.RR_EN(RR_EN)) u_pick (
    .req    (req),
    .last   (last),
    .winner (win_id),
    .any    (win_any)
  );

  // A winner with both a read and a write pending is served read-first
  assign win_ar = win_id ? m1.arvalid : m0.arvalid;

  // Owner-side views; address and data fields pass straight through
  assign own_arvalid = owner ? m1.arvalid : m0.arvalid;
  assign own_awvalid = owner ? m1.awvalid : m0.awvalid;
  assign own_wvalid  = owner ? m1.wvalid  : m0.wvalid;
  assign own_rready  = owner ? m1.rready  : m0.rready;
  assign own_bready  = owner ? m1.bready  : m0.bready;
  assign own_araddr  = owner ? m1.araddr  : m0.araddr;
  assign own_awaddr  = owner ? m1.awaddr  : m0.awaddr;
  assign own_wdata   = owner ? m1.wdata   : m0.wdata;
  assign own_wmask   = owner ? m1.wmask   : m0.wmask;

  // AW and W complete independently; each channel goes quiet once its flag is set
  assign aw_hs  = ~aw_done & own_awvalid & s.awready;
  assign w_hs   = ~w_done  & own_wvalid  & s.wready;
  assign aw_fin = aw_done | aw_hs;
  assign w_fin  = w_done  | w_hs;

  // State register plus owner, last-served and write-channel completion flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      last    <= last_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
    end
  end

  // Next-state: arbitrate in IDLE, then follow the owner's transaction to its response
  always_comb begin
    state_n   = state;
    owner_n   = owner;
    last_n    = last;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    case (state)
      IDLE: begin
        if (win_any) begin
          owner_n = win_id;
          state_n = win_ar ? RD_ADDR : WR_ADDR;
        end
      end
      RD_ADDR: begin
        if (own_arvalid && s.arready) state_n = RD_DATA;
      end
      RD_DATA: begin
        if (s.rvalid && own_rready) begin
          state_n = IDLE;
          last_n  = owner;
        end
      end
      WR_ADDR: begin
        if (aw_fin && w_fin) begin
          state_n   = WR_RESP;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
        end else begin
          aw_done_n = aw_fin;
          w_done_n  = w_fin;
        end
      end
      WR_RESP: begin
        if (s.bvalid && own_bready) begin
          state_n = IDLE;
          last_n  = owner;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs: connect the channel of the current phase between owner and downstream
  always_comb begin
    s.araddr  = own_araddr;
    s.awaddr  = own_awaddr;
    s.wdata   = own_wdata;
    s.wmask   = own_wmask;
    s.arvalid = 1'b0;
    s.rready  = 1'b0;
    s.awvalid = 1'b0;
    s.wvalid  = 1'b0;
    s.bready  = 1'b0;
    o_arready = 1'b0;
    o_rvalid  = 1'b0;
    o_awready = 1'b0;
    o_wready  = 1'b0;
    o_bvalid  = 1'b0;
    grant     = 2'b00;
    case (state)
      RD_ADDR: begin
        s.arvalid = own_arvalid;
        o_arready = s.arready;
      end
      RD_DATA: begin
        s.rready = own_rready;
        o_rvalid = s.rvalid;
      end
      WR_ADDR: begin
        s.awvalid = own_awvalid & ~aw_done;
        s.wvalid  = own_wvalid & ~w_done;
        o_awready = s.awready & ~aw_done;
        o_wready  = s.wready & ~w_done;
      end
      WR_RESP: begin
        s.bready = own_bready;
        o_bvalid = s.bvalid;
      end
      default: ;
    endcase
    if (state != IDLE) grant = owner ? 2'b10 : 2'b01;
  end

  assign rdata_bc = s.rdata;

  assign m0.arready = o_arready & ~owner;
  assign m0.rvalid  = o_rvalid  & ~owner;
  assign m0.awready = o_awready & ~owner;
  assign m0.wready  = o_wready  & ~owner;
  assign m0.bvalid  = o_bvalid  & ~owner;
  assign m0.rdata   = rdata_bc;
  assign m0.rresp   = s.rresp;
  assign m0.bresp   = s.bresp;

  assign m1.arready = o_arready & owner;
  assign m1.rvalid  = o_rvalid  & owner;
  assign m1.awready = o_awready & owner;
  assign m1.wready  = o_wready  & owner;
  assign m1.bvalid  = o_bvalid  & owner;
  assign m1.rdata   = rdata_bc;
  assign m1.rresp   = s.rresp;
  assign m1.bresp   = s.bresp;

  // Upstream masters must hold each valid until its handshake
  a_m0_ar: assert property (@(posedge clk) disable iff (reset) (m0.arvalid && !m0.arready) |=> m0.arvalid);
  a_m0_aw: assert property (@(posedge clk) disable iff (reset) (m0.awvalid && !m0.awready) |=> m0.awvalid);
  a_m0_w:  assert property (@(posedge clk) disable iff (reset) (m0.wvalid && !m0.wready) |=> m0.wvalid);
  a_m1_ar: assert property (@(posedge clk) disable iff (reset) (m1.arvalid && !m1.arready) |=> m1.arvalid);
  a_m1_aw: assert property (@(posedge clk) disable iff (reset) (m1.awvalid && !m1.awready) |=> m1.awvalid);
  a_m1_w:  assert property (@(posedge clk) disable iff (reset) (m1.wvalid && !m1.wready) |=> m1.wvalid);

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb/tb_axi_lite_arbiter.sv - directed self-checking bench for axi_lite_arbiter
module tb_axi_lite_arbiter;
  import axi_lite_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] grant;
  logic [1:0] grant_fp;
  int         checks = 0;
  int         errors = 0;

  axi_lite_if a0 ();
  axi_lite_if a1 ();
  axi_lite_if ds ();
  axi_lite_if f0 ();
  axi_lite_if f1 ();
  axi_lite_if fd ();

  axi_lite_arbiter #(.RR_EN(1'b1), .ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (a0),
    .m1    (a1),
    .s     (ds),
    .grant (grant)
  );

  axi_lite_arbiter #(.RR_EN(1'b0), .ADDR_W(32), .DATA_W(32)) dut_fp (
    .clk   (clk),
    .reset (reset),
    .m0    (f0),
    .m1    (f1),
    .s     (fd),
    .grant (grant_fp)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_all();
    a0.araddr = '0; a0.arvalid = 0; a0.rready = 0; a0.awaddr = '0; a0.awvalid = 0;
    a0.wdata = '0; a0.wmask = '0; a0.wvalid = 0; a0.bready = 0;
    a1.araddr = '0; a1.arvalid = 0; a1.rready = 0; a1.awaddr = '0; a1.awvalid = 0;
    a1.wdata = '0; a1.wmask = '0; a1.wvalid = 0; a1.bready = 0;
    f0.araddr = '0; f0.arvalid = 0; f0.rready = 0; f0.awaddr = '0; f0.awvalid = 0;
    f0.wdata = '0; f0.wmask = '0; f0.wvalid = 0; f0.bready = 0;
    f1.araddr = '0; f1.arvalid = 0; f1.rready = 0; f1.awaddr = '0; f1.awvalid = 0;
    f1.wdata = '0; f1.wmask = '0; f1.wvalid = 0; f1.bready = 0;
    ds.arready = 0; ds.rdata = '0; ds.rresp = '0; ds.rvalid = 0;
    ds.awready = 0; ds.wready = 0; ds.bresp = '0; ds.bvalid = 0;
    fd.arready = 0; fd.rdata = '0; fd.rresp = '0; fd.rvalid = 0;
    fd.awready = 0; fd.wready = 0; fd.bresp = '0; fd.bvalid = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_all();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_all();
    a0.arvalid = 1; a1.awvalid = 1; a1.wvalid = 1;
    ds.arready = 1; ds.awready = 1; ds.wready = 1; ds.rvalid = 1; ds.bvalid = 1;
    repeat (2) mid();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", grant); end
    checks++; if (grant_fp !== 2'b00) begin errors++; $display("FAIL reset_grant_fp got %b exp 00", grant_fp); end
    checks++;
    if ({ds.arvalid, ds.awvalid, ds.wvalid, ds.rready, ds.bready} !== 5'b0) begin
      errors++; $display("FAIL reset_s_valids got %b exp 00000", {ds.arvalid, ds.awvalid, ds.wvalid, ds.rready, ds.bready});
    end
    checks++;
    if ({a0.arready, a1.awready, a1.wready, a0.rvalid, a1.bvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_m_readies got %b exp 00000", {a0.arready, a1.awready, a1.wready, a0.rvalid, a1.bvalid});
    end
    apply_reset();
  endtask

  task automatic test_read_m0();
    apply_reset();
    a0.araddr = 32'h8000_0000; a0.arvalid = 1; a0.rready = 1;
    mid();
    checks++; if (ds.arvalid !== 1'b0) begin errors++; $display("FAIL rd_ar_latency got %b exp 0", ds.arvalid); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rd_grant_idle got %b exp 00", grant); end
    step();
    ds.arready = 1;
    mid();
    checks++; if (ds.arvalid !== 1'b1) begin errors++; $display("FAIL rd_s_arvalid got %b exp 1", ds.arvalid); end
    checks++; if (ds.araddr !== 32'h8000_0000) begin errors++; $display("FAIL rd_s_araddr got %h exp 80000000", ds.araddr); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rd_grant_addr got %b exp 01", grant); end
    checks++; if (a0.arready !== 1'b1) begin errors++; $display("FAIL rd_m0_arready got %b exp 1", a0.arready); end
    step();
    a0.arvalid = 0; ds.arready = 0; ds.rvalid = 1; ds.rdata = 32'h1234_5678; ds.rresp = RESP_OKAY;
    mid();
    checks++; if (a0.rvalid !== 1'b1) begin errors++; $display("FAIL rd_m0_rvalid got %b exp 1", a0.rvalid); end
    checks++; if (a0.rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_m0_rdata got %h exp 12345678", a0.rdata); end
    checks++; if (a0.rresp !== 2'b00) begin errors++; $display("FAIL rd_m0_rresp got %b exp 00", a0.rresp); end
    checks++; if (a1.rvalid !== 1'b0) begin errors++; $display("FAIL rd_m1_rvalid got %b exp 0", a1.rvalid); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rd_grant_data got %b exp 01", grant); end
    checks++; if (ds.rready !== 1'b1) begin errors++; $display("FAIL rd_s_rready got %b exp 1", ds.rready); end
    step();
    ds.rvalid = 0;
    mid();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rd_grant_done got %b exp 00", grant); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    a0.araddr = 32'h8000_0010; a0.arvalid = 1; a0.rready = 1;
    a1.awaddr = 32'ha000_03f8; a1.awvalid = 1; a1.wdata = 32'h41; a1.wmask = 4'h1; a1.wvalid = 1; a1.bready = 1;
    ds.arready = 1; ds.awready = 1; ds.wready = 1;
    mid();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL sim_grant_idle got %b exp 00", grant); end
    step();
    mid();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL sim_grant_first got %b exp 01", grant); end
    checks++; if (ds.araddr !== 32'h8000_0010) begin errors++; $display("FAIL sim_s_araddr got %h exp 80000010", ds.araddr); end
    checks++; if (ds.awvalid !== 1'b0) begin errors++; $display("FAIL sim_s_awvalid_held got %b exp 0", ds.awvalid); end
    checks++; if ({a1.awready, a1.wready} !== 2'b00) begin errors++; $display("FAIL sim_m1_held got %b exp 00", {a1.awready, a1.wready}); end
    step();
    a0.arvalid = 0; ds.rvalid = 1; ds.rdata = 32'hcafe_f00d; ds.rresp = RESP_OKAY;
    mid();
    checks++; if (a0.rvalid !== 1'b1) begin errors++; $display("FAIL sim_m0_rvalid got %b exp 1", a0.rvalid); end
    checks++; if (a0.rdata !== 32'hcafe_f00d) begin errors++; $display("FAIL sim_m0_rdata got %h exp cafef00d", a0.rdata); end
    checks++; if (a1.rvalid !== 1'b0) begin errors++; $display("FAIL sim_m1_rvalid got %b exp 0", a1.rvalid); end
    step();
    ds.rvalid = 0;
    mid();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL sim_gap got %b exp 00", grant); end
    step();
    mid();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL sim_grant_second got %b exp 10", grant); end
    checks++; if ({ds.awvalid, ds.wvalid} !== 2'b11) begin errors++; $display("FAIL sim_s_aw_w got %b exp 11", {ds.awvalid, ds.wvalid}); end
    checks++; if (ds.awaddr !== 32'ha000_03f8) begin errors++; $display("FAIL sim_s_awaddr got %h exp a00003f8", ds.awaddr); end
    checks++; if (ds.wdata !== 32'h41) begin errors++; $display("FAIL sim_s_wdata got %h exp 00000041", ds.wdata); end
    checks++; if (ds.wmask !== 4'h1) begin errors++; $display("FAIL sim_s_wmask got %h exp 1", ds.wmask); end
    step();
    a1.awvalid = 0; a1.wvalid = 0; ds.bvalid = 1; ds.bresp = RESP_OKAY;
    mid();
    checks++; if (a1.bvalid !== 1'b1) begin errors++; $display("FAIL sim_m1_bvalid got %b exp 1", a1.bvalid); end
    checks++; if (a1.bresp !== 2'b00) begin errors++; $display("FAIL sim_m1_bresp got %b exp 00", a1.bresp); end
    checks++; if (a0.bvalid !== 1'b0) begin errors++; $display("FAIL sim_m0_bvalid got %b exp 0", a0.bvalid); end
    checks++; if (ds.bready !== 1'b1) begin errors++; $display("FAIL sim_s_bready got %b exp 1", ds.bready); end
    step();
    ds.bvalid = 0;
    mid();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL sim_grant_done got %b exp 00", grant); end
  endtask

  task automatic test_w_delayed();
    apply_reset();
    a1.awaddr = 32'h0000_0100; a1.awvalid = 1; a1.wdata = 32'hdead_beef; a1.wmask = 4'hf;
    a1.wvalid = 1; a1.bready = 1;
    ds.awready = 1; ds.wready = 0;
    mid();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL wd_grant_idle got %b exp 00", grant); end
    step();
    mid();
    checks++; if ({ds.awvalid, ds.wvalid} !== 2'b11) begin errors++; $display("FAIL wd_n_aw_w got %b exp 11", {ds.awvalid, ds.wvalid}); end
    checks++; if ({a1.awready, a1.wready} !== 2'b10) begin errors++; $display("FAIL wd_n_readies got %b exp 10", {a1.awready, a1.wready}); end
    step();
    mid();
    checks++; if (ds.awvalid !== 1'b0) begin errors++; $display("FAIL wd_n1_awvalid got %b exp 0", ds.awvalid); end
    checks++; if (a1.awready !== 1'b0) begin errors++; $display("FAIL wd_n1_awready got %b exp 0", a1.awready); end
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL wd_n1_grant got %b exp 10", grant); end
    step();
    mid();
    checks++; if ({ds.awvalid, ds.bready} !== 2'b00) begin errors++; $display("FAIL wd_n2_aw_b got %b exp 00", {ds.awvalid, ds.bready}); end
    step();
    ds.wready = 1;
    mid();
    checks++; if ({ds.wvalid, a1.wready} !== 2'b11) begin errors++; $display("FAIL wd_n3_w got %b exp 11", {ds.wvalid, a1.wready}); end
    checks++; if ({ds.awvalid, ds.bready} !== 2'b00) begin errors++; $display("FAIL wd_n3_aw_b got %b exp 00", {ds.awvalid, ds.bready}); end
    step();
    a1.wvalid = 0; ds.bvalid = 1; ds.bresp = RESP_SLVERR;
    mid();
    checks++; if (ds.bready !== 1'b1) begin errors++; $display("FAIL wd_resp_bready got %b exp 1", ds.bready); end
    checks++; if ({ds.awvalid, ds.wvalid} !== 2'b00) begin errors++; $display("FAIL wd_resp_aw_w got %b exp 00", {ds.awvalid, ds.wvalid}); end
    checks++; if (a1.bvalid !== 1'b1) begin errors++; $display("FAIL wd_m1_bvalid got %b exp 1", a1.bvalid); end
    checks++; if (a1.bresp !== RESP_SLVERR) begin errors++; $display("FAIL wd_m1_bresp got %b exp 10", a1.bresp); end
    step();
    ds.bvalid = 0;
    mid();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL wd_grant_done got %b exp 00", grant); end
  endtask

  task automatic test_rr_alternate();
    logic [1:0] exp;
    int         n;
    apply_reset();
    a0.araddr = 32'h0000_1000; a0.arvalid = 1; a0.rready = 1;
    a1.araddr = 32'h0000_2000; a1.arvalid = 1; a1.rready = 1;
    ds.arready = 1; ds.rvalid = 1; ds.rdata = 32'h5555_aaaa;
    for (int t = 0; t < 8; t++) begin
      exp = (t % 2 == 0) ? 2'b01 : 2'b10;
      n = 0;
      while (grant == 2'b00 && n < 10) begin mid(); n++; end
      checks++; if (grant !== exp) begin errors++; $display("FAIL rr_grant_%0d got %b exp %b", t, grant, exp); end
      n = 0;
      while (grant != 2'b00 && n < 10) begin mid(); n++; end
      checks++; if (n >= 10) begin errors++; $display("FAIL rr_release_%0d got timeout exp idle", t); end
    end
  endtask

  task automatic test_fixed_priority();
    int n;
    apply_reset();
    f0.araddr = 32'h0000_3000; f0.arvalid = 1; f0.rready = 1;
    f1.araddr = 32'h0000_4000; f1.arvalid = 1; f1.rready = 1;
    fd.arready = 1; fd.rvalid = 1; fd.rdata = 32'h0f0f_0f0f;
    for (int t = 0; t < 8; t++) begin
      n = 0;
      while (grant_fp == 2'b00 && n < 10) begin mid(); n++; end
      checks++; if (grant_fp !== 2'b10) begin errors++; $display("FAIL fp_grant_%0d got %b exp 10", t, grant_fp); end
      n = 0;
      while (grant_fp != 2'b00 && n < 10) begin
        checks++; if (f0.rvalid !== 1'b0) begin errors++; $display("FAIL fp_m0_rvalid_%0d got %b exp 0", t, f0.rvalid); end
        mid(); n++;
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    a0.araddr = 32'h8000_0040; a0.arvalid = 1; a0.rready = 1;
    ds.arready = 1;
    step();
    step();
    a0.arvalid = 0; ds.arready = 0; ds.rvalid = 1; ds.rdata = 32'h0bad_0bad;
    mid();
    checks++; if ({grant, a0.rvalid, ds.rready} !== 4'b0111) begin
      errors++; $display("FAIL rm_before got %b exp 0111", {grant, a0.rvalid, ds.rready});
    end
    #1 reset = 1'b1;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rm_grant got %b exp 00", grant); end
    checks++; if (ds.rready !== 1'b0) begin errors++; $display("FAIL rm_s_rready got %b exp 0", ds.rready); end
    checks++; if (a0.rvalid !== 1'b0) begin errors++; $display("FAIL rm_m0_rvalid got %b exp 0", a0.rvalid); end
    ds.rvalid = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    a0.araddr = 32'h8000_0080; a0.arvalid = 1; ds.arready = 1;
    mid();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rm_fresh_idle got %b exp 00", grant); end
    step();
    mid();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rm_fresh_grant got %b exp 01", grant); end
    checks++; if (ds.araddr !== 32'h8000_0080) begin errors++; $display("FAIL rm_fresh_araddr got %h exp 80000080", ds.araddr); end
    step();
    a0.arvalid = 0; ds.arready = 0; ds.rvalid = 1; ds.rdata = 32'h600d_600d;
    mid();
    checks++; if (a0.rvalid !== 1'b1) begin errors++; $display("FAIL rm_fresh_rvalid got %b exp 1", a0.rvalid); end
    checks++; if (a0.rdata !== 32'h600d_600d) begin errors++; $display("FAIL rm_fresh_rdata got %h exp 600d600d", a0.rdata); end
    step();
    ds.rvalid = 0;
    mid();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rm_fresh_done got %b exp 00", grant); end
  endtask

  initial begin
    test_reset();
    test_read_m0();
    test_simultaneous();
    test_w_delayed();
    test_rr_alternate();
    test_fixed_priority();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
